// File: rtl/fifo_word_packer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_word_packer_pkg
//  Shared definitions for the FIFO word packer: default geometry, FSM state
//  encoding and the lane-mask helper used to build partial-word byte enables.
// ---------------------------------------------------------------------------
package fifo_word_packer_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int LANES_DEF = 4;
   localparam int MAX_LANES = 32;

   // Packer FSM encoding
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // Mask with the low n bits set; n == MAX_LANES yields all ones.
   function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned n);
      return MAX_LANES'((33'd1 << n) - 33'd1);
   endfunction

endpackage

// File: rtl/fifo_word_packer_vr_hold_reg.sv
// ---------------------------------------------------------------------------
// vr_hold_reg
//  Single-entry valid/ready output register. A load captures load_data and
//  raises valid; valid drops once the consumer accepts and nothing new loads.
//  The caller only loads when the slot is free (!valid | ready), so data is
//  stable while valid & !ready.
// Ports
//  rd_clk     clock
//  reset_n    synchronous active-low reset (clears valid and data)
//  load       capture load_data this cycle
//  load_data  DW-bit payload
//  ready      consumer accept
//  valid      payload valid
//  data       held payload
// ---------------------------------------------------------------------------
module vr_hold_reg #(
   parameter int DW = 8
) (
   input  logic          rd_clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] data
);

   always_ff @(posedge rd_clk) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// ---------------------------------------------------------------------------
// fifo_word_packer
//  Read-side consumer of the async FIFO (rd_clk domain). Pops WIDTH-bit
//  entries, packs LANES of them into one word (lane 0 = oldest) and offers it
//  on a valid/ready port. A flush pulse drains in-flight data and emits any
//  partial word with a lane-valid mask, then pulses flush_done.
// Ports
//  rd_clk      clock (FIFO read clock)
//  reset_n     synchronous active-low reset
//  fifo_empty  FIFO empty flag
//  fifo_data   FIFO read data, valid the cycle after fifo_read
//  fifo_read   pop request
//  flush       single-cycle request to emit any partial word
//  word_out    packed word
//  byte_en     lane-valid mask for word_out
//  word_valid  word_out/byte_en valid
//  word_ready  consumer accept
//  flush_done  one-cycle pulse when a flush completes
// ---------------------------------------------------------------------------
module fifo_word_packer
   import fifo_word_packer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LANES = LANES_DEF
) (
   input  logic                   rd_clk,
   input  logic                   reset_n,
   input  logic                   fifo_empty,
   input  logic [WIDTH-1:0]       fifo_data,
   output logic                   fifo_read,
   input  logic                   flush,
   output logic [WIDTH*LANES-1:0] word_out,
   output logic [LANES-1:0]       byte_en,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic                   flush_done
);

   localparam int LW = $clog2(LANES);
   localparam int CW = LW + 1;

   logic [CW-1:0]                 cnt;      // lanes captured in acc
   logic                          pending;  // read issued last cycle, data arriving now
   logic [0:0]                    state;
   logic [LANES-1:0][WIDTH-1:0]   acc;

   logic                          full, slot_free, xfer, drain_idle, partial, emit;
   logic [CW:0]                   occupancy;
   logic [LANES-1:0]              be_next;
   logic [LANES-1:0][WIDTH-1:0]   word_next;

   assign full       = (cnt == CW'(LANES));
   assign slot_free  = !word_valid || word_ready;
   assign xfer       = full && slot_free;
   assign drain_idle = (state == ST_DRAIN) && !pending;
   assign partial    = drain_idle && (cnt != '0) && !full && slot_free;
   assign emit       = xfer || partial;

   // Lanes already owned: captured plus the one still in flight from the FIFO.
   // A read is allowed when there is room, or when a full word leaves this cycle.
   assign occupancy  = {1'b0, cnt} + (CW+1)'(pending);
   assign fifo_read  = reset_n && (state == ST_RUN) && !flush && !fifo_empty &&
                       ((occupancy < (CW+1)'(LANES)) || xfer);

   // cnt == LANES gives all ones, so one expression serves full and partial words.
   assign be_next = LANES'(lane_mask(32'(cnt)));

   // Unfilled lanes may hold stale data from an earlier word; zero them.
   always_comb begin
      word_next = '0;
      for (int i = 0; i < LANES; i++)
         if (be_next[i]) word_next[i] = acc[i];
   end

   always_ff @(posedge rd_clk) begin
      if (!reset_n) begin
         cnt        <= '0;
         pending    <= 1'b0;
         state      <= ST_RUN;
         flush_done <= 1'b0;
         acc        <= '0;
      end else begin
         pending    <= fifo_read;
         flush_done <= 1'b0;
         // capture and emit are exclusive: emit needs pending=0 (partial) or
         // cnt==LANES, and cnt+pending never exceeds LANES.
         if (pending) begin
            acc[cnt[LW-1:0]] <= fifo_data;
            cnt              <= cnt + CW'(1);
         end else if (emit) begin
            cnt <= '0;
         end
         case (state)
            ST_RUN: if (flush) state <= ST_DRAIN;
            default: begin
               // Nothing left in flight or in the accumulator: flush complete.
               if (drain_idle && (cnt == '0)) begin
                  state      <= ST_RUN;
                  flush_done <= 1'b1;
               end
            end
         endcase
      end
   end

   vr_hold_reg #(.DW(WIDTH*LANES + LANES)) u_hold (
      .rd_clk    (rd_clk),
      .reset_n   (reset_n),
      .load      (emit),
      .load_data ({be_next, word_next}),
      .ready     (word_ready),
      .valid     (word_valid),
      .data      ({byte_en, word_out})
   );

endmodule
